uart_reg_slave: RTL and testbench

UART_REG_SLAVE -- requirements
Module: uart_reg_slave

---
 rtl/uart_reg_slave.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_uart_reg_slave.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : uart_reg_slave
// Description : Register-mapped 8N1 UART with 4-entry TX and RX FIFOs,
//               a line status register and sticky overrun/framing flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_reg_slave #(
   parameter int CLKS_PER_BIT = 234
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_en,
   input  logic [2:0] waddr,
   input  logic [7:0] wdata,
   input  logic       rx_en,
   input  logic [2:0] raddr,
   output logic [7:0] rdata,
   input  logic       sin,
   output logic       sout,
   output logic       rx_rdy_n,
   output logic       tx_rdy_n,
   output logic       intr
);

   localparam int              c_bw        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_bw-1:0] c_bit_last  = c_bw'(CLKS_PER_BIT - 1);
   localparam logic [c_bw-1:0] c_half_last = c_bw'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // ---------------------------------------------------------------- TX FIFO
   logic [7:0] r_tx_mem [0:3];
   logic [1:0] r_tx_wr, r_tx_rd;
   logic [2:0] r_tx_cnt;
   logic       w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;

   assign w_tx_full  = (r_tx_cnt == 3'd4);
   assign w_tx_empty = (r_tx_cnt == 3'd0);
   assign w_tx_push  = tx_en && (waddr == 3'd0) && !w_tx_full;

   // TX FIFO storage; contents need no reset because occupancy guards reads
   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wr] <= wdata;
   end

   // TX FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_wr  <= 2'd0;
         r_tx_rd  <= 2'd0;
         r_tx_cnt <= 3'd0;
      end else begin
         if (w_tx_push) r_tx_wr <= r_tx_wr + 2'd1;
         if (w_tx_pop)  r_tx_rd <= r_tx_rd + 2'd1;
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_cnt <= r_tx_cnt + 3'd1;
            2'b01:   r_tx_cnt <= r_tx_cnt - 3'd1;
            default: r_tx_cnt <= r_tx_cnt;
         endcase
      end
   end

   // ---------------------------------------------------------------- TX FSM
   tx_state_t       r_tx_state, w_tx_state_nx;
   logic [c_bw-1:0] r_tx_baud, w_tx_baud_nx;
   logic [2:0]      r_tx_bit, w_tx_bit_nx;
   logic [7:0]      r_tx_shift, w_tx_shift_nx;
   logic            r_sout, w_sout_nx;
   logic            w_tx_bit_end;

   assign w_tx_bit_end = (r_tx_baud == c_bit_last);

   // TX state and shifter registers; sout is registered so it never glitches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_state <= TX_IDLE;
         r_tx_baud  <= '0;
         r_tx_bit   <= 3'd0;
         r_tx_shift <= 8'h00;
         r_sout     <= 1'b1;
      end else begin
         r_tx_state <= w_tx_state_nx;
         r_tx_baud  <= w_tx_baud_nx;
         r_tx_bit   <= w_tx_bit_nx;
         r_tx_shift <= w_tx_shift_nx;
         r_sout     <= w_sout_nx;
      end
   end

   // TX next-state: a new byte is loaded from IDLE or straight from STOP
   always_comb begin
      w_tx_state_nx = r_tx_state;
      w_tx_baud_nx  = r_tx_baud;
      w_tx_bit_nx   = r_tx_bit;
      w_tx_shift_nx = r_tx_shift;
      w_sout_nx     = r_sout;
      w_tx_pop      = 1'b0;
      case (r_tx_state)
         TX_IDLE: begin
            w_sout_nx = 1'b1;
            if (!w_tx_empty) begin
               w_tx_pop      = 1'b1;
               w_tx_shift_nx = r_tx_mem[r_tx_rd];
               w_tx_baud_nx  = '0;
               w_tx_state_nx = TX_START;
               w_sout_nx     = 1'b0;
            end
         end
         TX_START: begin
            if (w_tx_bit_end) begin
               w_tx_baud_nx  = '0;
               w_tx_bit_nx   = 3'd0;
               w_tx_state_nx = TX_DATA;
               w_sout_nx     = r_tx_shift[0];
            end else begin
               w_tx_baud_nx = r_tx_baud + 1'b1;
            end
         end
         TX_DATA: begin
            if (w_tx_bit_end) begin
               w_tx_baud_nx = '0;
               if (r_tx_bit == 3'd7) begin
                  w_tx_state_nx = TX_STOP;
                  w_sout_nx     = 1'b1;
               end else begin
                  w_tx_bit_nx   = r_tx_bit + 3'd1;
                  w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
                  w_sout_nx     = r_tx_shift[1];
               end
            end else begin
               w_tx_baud_nx = r_tx_baud + 1'b1;
            end
         end
         TX_STOP: begin
            if (w_tx_bit_end) begin
               w_tx_baud_nx = '0;
               if (!w_tx_empty) begin
                  w_tx_pop      = 1'b1;
                  w_tx_shift_nx = r_tx_mem[r_tx_rd];
                  w_tx_state_nx = TX_START;
                  w_sout_nx     = 1'b0;
               end else begin
                  w_tx_state_nx = TX_IDLE;
                  w_sout_nx     = 1'b1;
               end
            end else begin
               w_tx_baud_nx = r_tx_baud + 1'b1;
            end
         end
         default: begin
            w_tx_state_nx = TX_IDLE;
            w_sout_nx     = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------- RX sync
   logic r_sin_meta, r_sin_sync, r_sin_prev;

   // Two-flop synchroniser plus one history flop for falling-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sin_meta <= 1'b1;
         r_sin_sync <= 1'b1;
         r_sin_prev <= 1'b1;
      end else begin
         r_sin_meta <= sin;
         r_sin_sync <= r_sin_meta;
         r_sin_prev <= r_sin_sync;
      end
   end

   // ---------------------------------------------------------------- RX FSM
   rx_state_t       r_rx_state, w_rx_state_nx;
   logic [c_bw-1:0] r_rx_baud, w_rx_baud_nx;
   logic [2:0]      r_rx_bit, w_rx_bit_nx;
   logic [7:0]      r_rx_shift, w_rx_shift_nx;
   logic            r_rx_brk, w_rx_brk_nx;
   logic            w_rx_push_req, w_fe_set;

   // RX state and shifter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_state <= RX_IDLE;
         r_rx_baud  <= '0;
         r_rx_bit   <= 3'd0;
         r_rx_shift <= 8'h00;
         r_rx_brk   <= 1'b0;
      end else begin
         r_rx_state <= w_rx_state_nx;
         r_rx_baud  <= w_rx_baud_nx;
         r_rx_bit   <= w_rx_bit_nx;
         r_rx_shift <= w_rx_shift_nx;
         r_rx_brk   <= w_rx_brk_nx;
      end
   end

   // RX next-state: half-bit start check, then mid-bit sampling; after a
   // framing error r_rx_brk holds STOP until the line returns high
   always_comb begin
      w_rx_state_nx = r_rx_state;
      w_rx_baud_nx  = r_rx_baud;
      w_rx_bit_nx   = r_rx_bit;
      w_rx_shift_nx = r_rx_shift;
      w_rx_brk_nx   = r_rx_brk;
      w_rx_push_req = 1'b0;
      w_fe_set      = 1'b0;
      case (r_rx_state)
         RX_IDLE: begin
            if (r_sin_prev && !r_sin_sync) begin
               w_rx_baud_nx  = '0;
               w_rx_state_nx = RX_START;
            end
         end
         RX_START: begin
            if (r_rx_baud == c_half_last) begin
               w_rx_baud_nx  = '0;
               w_rx_bit_nx   = 3'd0;
               w_rx_state_nx = r_sin_sync ? RX_IDLE : RX_DATA;
            end else begin
               w_rx_baud_nx = r_rx_baud + 1'b1;
            end
         end
         RX_DATA: begin
            if (r_rx_baud == c_bit_last) begin
               w_rx_baud_nx  = '0;
               w_rx_shift_nx = {r_sin_sync, r_rx_shift[7:1]};
               if (r_rx_bit == 3'd7) w_rx_state_nx = RX_STOP;
               else                  w_rx_bit_nx   = r_rx_bit + 3'd1;
            end else begin
               w_rx_baud_nx = r_rx_baud + 1'b1;
            end
         end
         RX_STOP: begin
            if (r_rx_brk) begin
               if (r_sin_sync) begin
                  w_rx_brk_nx   = 1'b0;
                  w_rx_state_nx = RX_IDLE;
               end
            end else if (r_rx_baud == c_bit_last) begin
               w_rx_baud_nx = '0;
               if (r_sin_sync) begin
                  w_rx_push_req = 1'b1;
                  w_rx_state_nx = RX_IDLE;
               end else begin
                  w_fe_set    = 1'b1;
                  w_rx_brk_nx = 1'b1;
               end
            end else begin
               w_rx_baud_nx = r_rx_baud + 1'b1;
            end
         end
         default: w_rx_state_nx = RX_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- RX FIFO
   logic [7:0] r_rx_mem [0:3];
   logic [1:0] r_rx_wr, r_rx_rd;
   logic [2:0] r_rx_cnt;
   logic       w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_oe_set;

   assign w_rx_full  = (r_rx_cnt == 3'd4);
   assign w_rx_empty = (r_rx_cnt == 3'd0);
   assign w_rx_push  = w_rx_push_req && !w_rx_full;
   assign w_oe_set   = w_rx_push_req && w_rx_full;
   assign w_rx_pop   = rx_en && (raddr == 3'd0) && !w_rx_empty;

   // RX FIFO storage
   always_ff @(posedge clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wr] <= r_rx_shift;
   end

   // RX FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_wr  <= 2'd0;
         r_rx_rd  <= 2'd0;
         r_rx_cnt <= 3'd0;
      end else begin
         if (w_rx_push) r_rx_wr <= r_rx_wr + 2'd1;
         if (w_rx_pop)  r_rx_rd <= r_rx_rd + 2'd1;
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + 3'd1;
            2'b01:   r_rx_cnt <= r_rx_cnt - 3'd1;
            default: r_rx_cnt <= r_rx_cnt;
         endcase
      end
   end

   // ---------------------------------------------------------------- status
   logic       r_oe, r_fe;
   logic       w_lsr_rd, w_temt;
   logic [7:0] w_lsr, w_rdata_nx;
   logic [7:0] r_rdata;

   assign w_lsr_rd = rx_en && (raddr == 3'd5);
   assign w_temt   = w_tx_empty && (r_tx_state == TX_IDLE);
   assign w_lsr    = {1'b0, w_temt, w_tx_empty, w_tx_full, r_fe, 1'b0, r_oe, !w_rx_empty};

   // Sticky error flags: a new error in the same cycle beats the read-clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_oe <= 1'b0;
         r_fe <= 1'b0;
      end else begin
         if (w_oe_set)      r_oe <= 1'b1;
         else if (w_lsr_rd) r_oe <= 1'b0;
         if (w_fe_set)      r_fe <= 1'b1;
         else if (w_lsr_rd) r_fe <= 1'b0;
      end
   end

   // Read data mux; unmapped addresses and an empty RX FIFO read as zero
   always_comb begin
      w_rdata_nx = 8'h00;
      if (raddr == 3'd0) begin
         if (!w_rx_empty) w_rdata_nx = r_rx_mem[r_rx_rd];
      end else if (raddr == 3'd5) begin
         w_rdata_nx = w_lsr;
      end
   end

   // Read data register, updated only by a read strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_rdata <= 8'h00;
      else if (rx_en) r_rdata <= w_rdata_nx;
   end

   assign rdata    = r_rdata;
   assign sout     = r_sout;
   assign rx_rdy_n = w_rx_empty;
   assign tx_rdy_n = w_tx_full;
   assign intr     = !w_rx_empty || r_oe || r_fe;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_reg_slave
// Description : Directed self-checking bench for uart_reg_slave, CLKS_PER_BIT=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_reg_slave;

   localparam int c_cpb = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx_en;
   logic [2:0] waddr;
   logic [7:0] wdata;
   logic       rx_en;
   logic [2:0] raddr;
   logic [7:0] rdata;
   logic       sin;
   logic       sout;
   logic       rx_rdy_n;
   logic       tx_rdy_n;
   logic       intr;

   int checks   = 0;
   int failures = 0;

   uart_reg_slave #(.CLKS_PER_BIT(c_cpb)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_en    (tx_en),
      .waddr    (waddr),
      .wdata    (wdata),
      .rx_en    (rx_en),
      .raddr    (raddr),
      .rdata    (rdata),
      .sin      (sin),
      .sout     (sout),
      .rx_rdy_n (rx_rdy_n),
      .tx_rdy_n (tx_rdy_n),
      .intr     (intr)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Safety net against a stalled run
   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [2:0] a, input logic [7:0] d);
      tx_en = 1'b1;
      waddr = a;
      wdata = d;
      tick();
      tx_en = 1'b0;
   endtask

   task automatic do_read(input logic [2:0] a);
      rx_en = 1'b1;
      raddr = a;
      tick();
      rx_en = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      sin = 1'b0;
      repeat (c_cpb) tick();
      for (int b = 0; b < 8; b++) begin
         sin = d[b];
         repeat (c_cpb) tick();
      end
      sin = stop_bit;
      repeat (c_cpb) tick();
      sin = 1'b1;
      repeat (4) tick();
   endtask

   // Samples sout once per bit, starting mid start bit; ends mid next start bit
   task automatic capture_frame(output logic [9:0] bits);
      for (int b = 0; b < 10; b++) begin
         bits[b] = sout;
         repeat (c_cpb) tick();
      end
   endtask

   logic [9:0] fr;
   logic [9:0] cap;

   initial begin
      rst_n = 1'b0;
      tx_en = 1'b0;
      waddr = 3'd0;
      wdata = 8'h00;
      rx_en = 1'b0;
      raddr = 3'd0;
      sin   = 1'b1;

      // ---------------- reset state
      repeat (3) tick();
      check("rst_sout", 16'(sout), 16'h1);
      check("rst_rdata", 16'(rdata), 16'h00);
      check("rst_rx_rdy_n", 16'(rx_rdy_n), 16'h1);
      check("rst_tx_rdy_n", 16'(tx_rdy_n), 16'h0);
      check("rst_intr", 16'(intr), 16'h0);
      rst_n = 1'b1;
      repeat (2) tick();
      do_read(3'd5);
      check("rst_lsr", 16'(rdata), 16'h60);

      // ---------------- single TX frame 0x55, cycle-exact
      do_write(3'd0, 8'h55);
      check("tx55_pre", 16'(sout), 16'h1);
      fr = {1'b1, 8'h55, 1'b0};
      for (int i = 0; i < 10 * c_cpb; i++) begin
         tick();
         check("tx55_bit", 16'(sout), 16'(fr[i / c_cpb]));
      end
      tick();
      do_read(3'd5);
      check("tx55_temt_lsr", 16'(rdata), 16'h60);

      // ---------------- five back-to-back writes
      for (int k = 1; k <= 5; k++) begin
         tx_en = 1'b1;
         waddr = 3'd0;
         wdata = 8'(k);
         tick();
      end
      tx_en = 1'b0;
      check("b2b_tx_rdy_n_full", 16'(tx_rdy_n), 16'h1);
      do_read(3'd5);
      check("b2b_lsr_full", 16'(rdata), 16'h10);
      for (int k = 1; k <= 5; k++) begin
         capture_frame(cap);
         check("b2b_frame", 16'(cap), 16'({1'b1, 8'(k), 1'b0}));
         if (k == 1) check("b2b_tx_rdy_n_after_pop2", 16'(tx_rdy_n), 16'h0);
      end
      check("b2b_idle_sout", 16'(sout), 16'h1);
      repeat (2) tick();
      do_read(3'd5);
      check("b2b_lsr_done", 16'(rdata), 16'h60);

      // ---------------- ignored write address and unmapped read
      do_write(3'd1, 8'h77);
      repeat (3) tick();
      check("waddr1_sout", 16'(sout), 16'h1);
      do_read(3'd3);
      check("raddr3_rdata", 16'(rdata), 16'h00);
      do_read(3'd5);
      check("waddr1_lsr", 16'(rdata), 16'h60);

      // ---------------- RX frame 0xA3
      send_frame(8'hA3, 1'b1);
      check("rxA3_rx_rdy_n", 16'(rx_rdy_n), 16'h0);
      check("rxA3_intr", 16'(intr), 16'h1);
      do_read(3'd5);
      check("rxA3_lsr", 16'(rdata), 16'h61);
      do_read(3'd0);
      check("rxA3_data", 16'(rdata), 16'hA3);
      check("rxA3_rx_rdy_n_after", 16'(rx_rdy_n), 16'h1);
      check("rxA3_intr_after", 16'(intr), 16'h0);
      tick();
      check("rxA3_rdata_hold", 16'(rdata), 16'hA3);

      // ---------------- overrun with five frames
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      send_frame(8'h33, 1'b1);
      send_frame(8'h44, 1'b1);
      send_frame(8'h55, 1'b1);
      do_read(3'd5);
      check("oe_lsr", 16'(rdata), 16'h63);
      do_read(3'd5);
      check("oe_lsr_cleared", 16'(rdata), 16'h61);
      do_read(3'd0);
      check("oe_rd0", 16'(rdata), 16'h11);
      do_read(3'd0);
      check("oe_rd1", 16'(rdata), 16'h22);
      do_read(3'd0);
      check("oe_rd2", 16'(rdata), 16'h33);
      do_read(3'd0);
      check("oe_rd3", 16'(rdata), 16'h44);
      check("oe_rx_rdy_n", 16'(rx_rdy_n), 16'h1);
      do_read(3'd0);
      check("oe_rd_empty", 16'(rdata), 16'h00);

      // ---------------- framing error and glitch
      send_frame(8'h5A, 1'b0);
      check("fe_rx_rdy_n", 16'(rx_rdy_n), 16'h1);
      check("fe_intr", 16'(intr), 16'h1);
      do_read(3'd5);
      check("fe_lsr", 16'(rdata), 16'h68);
      check("fe_intr_cleared", 16'(intr), 16'h0);
      sin = 1'b0;
      repeat (3) tick();
      sin = 1'b1;
      repeat (40) tick();
      check("glitch_rx_rdy_n", 16'(rx_rdy_n), 16'h1);
      do_read(3'd5);
      check("glitch_lsr", 16'(rdata), 16'h60);

      // ---------------- reset in the middle of TX and RX frames
      do_write(3'd0, 8'hC3);
      repeat (20) tick();
      sin = 1'b0;
      repeat (30) tick();
      check("midrst_sout_busy", 16'(sout), 16'(1'b0));
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_sout", 16'(sout), 16'h1);
      check("midrst_rdata", 16'(rdata), 16'h00);
      repeat (3) tick();
      sin   = 1'b1;
      rst_n = 1'b1;
      repeat (3) tick();
      check("postrst_sout", 16'(sout), 16'h1);
      do_read(3'd5);
      check("postrst_lsr", 16'(rdata), 16'h60);
      send_frame(8'h3C, 1'b1);
      do_read(3'd0);
      check("postrst_rx", 16'(rdata), 16'h3C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
